axis_vid_frame_check: RTL and testbench

- Sits directly downstream of the BRAM-backed video image source, between its AXI-Stream master and the video output / VDMA path.
- Passes the 24-bit video stream through a registered skid buffer, so the source sees a registered tready.
- Checks frame structure against SCRW x SCRH using tuser (SOF) and tlast (EOL).
- Reports sticky error flags, a frame counter and the current position for debug/ILA.

---
 rtl/axis_vid_if.sv | 12 +
 rtl/axis_vid_frame_check.sv | 115 +++++++++++
 tb/tb_axis_vid_frame_check.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_vid_if.sv
// axis_vid_if: AXI-Stream video bus (pixel data, valid/ready, SOF in tuser, EOL in tlast)
interface axis_vid_if #(
  parameter int DATAW = 24
);
  logic [DATAW-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tuser;
  logic             tlast;
  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/axis_vid_frame_check.sv
// axis_vid_frame_check: skid-buffered AXIS video pass-through with SOF/EOL frame-geometry checking
//   clk, rstn (async, active low), err_clr (sync pulse clearing sticky errors)
//   s_axis : upstream stream (registered tready), m_axis : downstream stream (1-cycle latency)
//   pix_pos/line_pos : position of the next expected beat, frame_cnt : completed frames,
//   frame_done : pulse after the last beat of a frame, err : sticky {late EOL, early EOL, early SOF, no SOF}
//   frame_sum : per-frame data checksum, only when FRAME_CHECKSUM_EN is defined (else 0)
module axis_vid_frame_check #(
  parameter int DATAW = 24,
  parameter int SCRW  = 1920,
  parameter int SCRH  = 1080,
  parameter int FCNTW = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             err_clr,
  axis_vid_if.slave        s_axis,
  axis_vid_if.master       m_axis,
  output logic [12:0]      pix_pos,
  output logic [12:0]      line_pos,
  output logic [FCNTW-1:0] frame_cnt,
  output logic             frame_done,
  output logic [3:0]       err,
  output logic [31:0]      frame_sum
);
  typedef enum logic {WAIT_SOF, IN_FRAME} state_t;
  localparam logic [12:0] PMAX = 13'(SCRW - 1);
  localparam logic [12:0] LMAX = 13'(SCRH - 1);
  state_t st, st_n;
  logic acc, out_free, k_valid, k_valid_n, k_user, k_last, done_n;
  logic [DATAW-1:0] k_data;
  logic [12:0] p, l, pix_n, line_n;
  logic [3:0] err_set;
  assign acc = s_axis.tvalid && s_axis.tready;
  assign out_free = !m_axis.tvalid || m_axis.tready;
  // tready is only high while the skid is empty, so a beat accepted during a stall always fits there
  assign k_valid_n = out_free ? 1'b0 : (k_valid || acc);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      s_axis.tready <= 1'b0;
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tuser  <= 1'b0;
      m_axis.tlast  <= 1'b0;
      k_valid       <= 1'b0;
      k_data        <= '0;
      k_user        <= 1'b0;
      k_last        <= 1'b0;
    end else begin
      s_axis.tready <= !k_valid_n;
      k_valid       <= k_valid_n;
      if (!out_free && acc)
        {k_data, k_user, k_last} <= {s_axis.tdata, s_axis.tuser, s_axis.tlast};
      if (out_free) begin
        m_axis.tvalid <= k_valid || acc;
        if (k_valid)
          {m_axis.tdata, m_axis.tuser, m_axis.tlast} <= {k_data, k_user, k_last};
        else if (acc)
          {m_axis.tdata, m_axis.tuser, m_axis.tlast} <= {s_axis.tdata, s_axis.tuser, s_axis.tlast};
      end
    end
  // a SOF beat is always pixel 0 of line 0, whether it opens a frame or restarts one early
  always_comb begin
    st_n    = st;
    pix_n   = pix_pos;
    line_n  = line_pos;
    err_set = '0;
    done_n  = 1'b0;
    p       = s_axis.tuser ? '0 : pix_pos;
    l       = s_axis.tuser ? '0 : line_pos;
    if (acc) begin
      if (st == WAIT_SOF && !s_axis.tuser)
        err_set[0] = 1'b1;
      else begin
        err_set[1] = st == IN_FRAME && s_axis.tuser;
        err_set[2] = s_axis.tlast && p != PMAX;
        err_set[3] = !s_axis.tlast && p == PMAX;
        done_n     = s_axis.tlast && l == LMAX;
        pix_n      = s_axis.tlast ? '0 : (p == PMAX ? p : p + 13'd1);
        line_n     = !s_axis.tlast ? l : (done_n ? '0 : l + 13'd1);
        st_n       = done_n ? WAIT_SOF : IN_FRAME;
      end
    end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      st         <= WAIT_SOF;
      pix_pos    <= '0;
      line_pos   <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
      err        <= '0;
    end else begin
      st         <= st_n;
      pix_pos    <= pix_n;
      line_pos   <= line_n;
      frame_cnt  <= frame_cnt + FCNTW'(done_n);
      frame_done <= done_n;
      err        <= (err_clr ? 4'b0 : err) | err_set;
    end
`ifdef FRAME_CHECKSUM_EN
  logic [31:0] sum, sum_n;
  assign sum_n = s_axis.tuser ? 32'(s_axis.tdata) : sum + 32'(s_axis.tdata);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      sum       <= '0;
      frame_sum <= '0;
    end else if (acc && (st == IN_FRAME || s_axis.tuser)) begin
      sum <= sum_n;
      if (done_n)
        frame_sum <= sum_n;
    end
`else
  assign frame_sum = '0;
`endif
endmodule

// File: tb/tb_axis_vid_frame_check.sv
// tb_axis_vid_frame_check: directed/random bench for axis_vid_frame_check against a frame-geometry model
module tb_axis_vid_frame_check;
  localparam int SCRW = 8;
  localparam int SCRH = 4;
  logic clk, rstn, err_clr, frame_done;
  logic [12:0] pix_pos, line_pos;
  logic [15:0] frame_cnt;
  logic [3:0] err;
  logic [31:0] frame_sum;
  axis_vid_if #(.DATAW(24)) s_if ();
  axis_vid_if #(.DATAW(24)) m_if ();
  axis_vid_frame_check #(.DATAW(24), .SCRW(SCRW), .SCRH(SCRH), .FCNTW(16)) dut (
    .clk(clk), .rstn(rstn), .err_clr(err_clr), .s_axis(s_if), .m_axis(m_if),
    .pix_pos(pix_pos), .line_pos(line_pos), .frame_cnt(frame_cnt),
    .frame_done(frame_done), .err(err), .frame_sum(frame_sum)
  );
  int total = 0, bad = 0, cyc = 0, low_at = -100, done_seen = 0;
  bit rnd = 0, gaps = 0, lat = 0, pat = 0;
  logic [25:0] exp_q[$];
  bit m_in = 0;
  int m_pix = 0, m_line = 0, m_cnt = 0, m_done = 0;
  logic [3:0] m_err = 0;
  logic [31:0] m_sum = 0, m_fsum = 0;
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask
  // sink: ready is random in backpressure phases, plus a forced 4-cycle low window
  always @(negedge clk)
    m_if.tready = (cyc >= low_at && cyc < low_at + 4) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
  // output monitor: ordering/no loss, stall stability, tready reaction, frame_done pulses
  logic [26:0] held;
  bit hold = 0, ck_rdy = 0;
  always @(posedge clk)
    if (!rstn) begin
      hold = 0;
      ck_rdy = 0;
    end else begin
      if (hold) chk("stall_stable", {m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata}, held);
      if (ck_rdy) chk("s_tready_fall", s_if.tready, 0);
      ck_rdy = s_if.tvalid && s_if.tready && m_if.tvalid && !m_if.tready;
      hold = m_if.tvalid && !m_if.tready;
      held = {1'b1, m_if.tuser, m_if.tlast, m_if.tdata};
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) chk("extra_beat", exp_q.size(), 1);
        else chk("out_beat", {m_if.tuser, m_if.tlast, m_if.tdata}, exp_q.pop_front());
      end
      if (frame_done) done_seen++;
    end
  // reference: position within the SCRW x SCRH raster implied by the accepted beats
  task automatic model_beat(input logic u, input logic l, input logic [23:0] d, input logic clr);
    logic [3:0] e = 0;
    if (!m_in && !u) e[0] = 1;
    else begin
      if (m_in && u) e[1] = 1;
      if (u) begin
        m_pix = 0;
        m_line = 0;
        m_sum = 32'(d);
      end else m_sum += 32'(d);
      m_in = 1;
      if (l) begin
        if (m_pix != SCRW - 1) e[2] = 1;
        m_pix = 0;
        m_line++;
        if (m_line == SCRH) begin
          m_line = 0;
          m_in = 0;
          m_cnt++;
          m_done++;
          m_fsum = m_sum;
        end
      end else if (m_pix == SCRW - 1) e[3] = 1;
      else m_pix++;
    end
    m_err = (clr ? 4'b0 : m_err) | e;
    exp_q.push_back({u, l, d});
  endtask
  task automatic send_beat(input logic u, input logic l, input logic [23:0] d, input logic clr);
    logic r;
    int n = 0;
    if (gaps && $urandom_range(0, 3) == 0) begin
      @(negedge clk);
      s_if.tvalid = 0;
      err_clr = 0;
    end
    do begin
      @(negedge clk);
      s_if.tvalid = 1;
      s_if.tdata = d;
      s_if.tuser = u;
      s_if.tlast = l;
      r = s_if.tready;
      err_clr = clr && r;
      n++;
      @(posedge clk);
    end while (!r && n < 200);
    if (!r) chk("accept_timeout", r, 1);
    else begin
      model_beat(u, l, d, clr);
      if (lat) begin
        #1;
        chk("latency", {m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata}, {1'b1, u, l, d});
      end
    end
  endtask
  function automatic logic [23:0] gen(input int ln, input int p);
    return pat ? 24'(ln * 8 + p) : 24'($urandom);
  endfunction
  task automatic send_line(input bit sof, input int n, input int ln, input bit eol, input bit clr);
    for (int p = 0; p < n; p++)
      send_beat(sof && p == 0, eol && p == n - 1, gen(ln, p), clr && p == n - 1);
  endtask
  task automatic send_frame();
    for (int ln = 0; ln < SCRH; ln++) send_line(ln == 0, SCRW, ln, 1, 0);
  endtask
  task automatic idle();
    @(negedge clk);
    s_if.tvalid = 0;
    err_clr = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      idle();
      n++;
    end
    chk("drain", exp_q.size(), 0);
    idle();
  endtask
  task automatic chk_state(input string tag);
    #1;
    chk({tag, "_pix"}, pix_pos, m_pix);
    chk({tag, "_line"}, line_pos, m_line);
    chk({tag, "_err"}, err, m_err);
    chk({tag, "_cnt"}, frame_cnt, m_cnt);
`ifdef FRAME_CHECKSUM_EN
    chk({tag, "_sum"}, frame_sum, m_fsum);
`else
    chk({tag, "_sum"}, frame_sum, 0);
`endif
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_mvalid"}, m_if.tvalid, 0);
    chk({tag, "_sready"}, s_if.tready, 0);
    chk({tag, "_mbeat"}, {m_if.tuser, m_if.tlast, m_if.tdata}, 0);
    chk({tag, "_pos"}, {pix_pos, line_pos}, 0);
    chk({tag, "_cnt"}, frame_cnt, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_sum"}, frame_sum, 0);
  endtask
  task automatic clear_err();
    @(negedge clk);
    s_if.tvalid = 0;
    err_clr = 1;
    @(posedge clk);
    m_err = 0;
    idle();
    chk("err_clr", err, 0);
  endtask
  initial begin
    rstn = 0;
    err_clr = 0;
    s_if.tvalid = 0;
    s_if.tdata = 0;
    s_if.tuser = 0;
    s_if.tlast = 0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rstn = 1;
    @(posedge clk);
    #1;
    chk("tready_after_reset", s_if.tready, 1);
    lat = 1;
    send_frame();
    lat = 0;
    chk_state("clean");
    chk("clean_err_zero", err, 0);
    drain();
    chk("clean_done", done_seen, m_done);
    rnd = 1;
    gaps = 1;
    low_at = cyc + 12;
    send_frame();
    rnd = 0;
    gaps = 0;
    drain();
    chk_state("backpressure");
    chk("bp_done", done_seen, m_done);
    send_line(1, SCRW, 0, 1, 0);
    send_line(0, 6, 1, 1, 0);
    chk_state("early_eol");
    chk("early_eol_err", err, 4'b0100);
    chk("early_eol_line", line_pos, 2);
    send_line(0, SCRW, 2, 1, 0);
    send_line(0, SCRW, 3, 1, 0);
    chk_state("early_eol_end");
    drain();
    clear_err();
    send_line(1, 10, 0, 1, 0);
    for (int ln = 1; ln < SCRH; ln++) send_line(0, SCRW, ln, 1, 0);
    send_beat(0, 0, gen(0, 0), 0);
    chk_state("late_eol");
    chk("late_eol_err", err, 4'b1001);
    drain();
    chk("late_eol_done", done_seen, m_done);
    clear_err();
    send_line(1, SCRW, 0, 1, 0);
    send_line(0, SCRW, 1, 1, 0);
    send_line(0, 3, 2, 0, 0);
    send_beat(1, 0, gen(0, 0), 0);
    chk_state("early_sof");
    chk("early_sof_err", err, 4'b0010);
    chk("early_sof_pos", {pix_pos, line_pos}, {13'd1, 13'd0});
    for (int p = 1; p < 5; p++) send_beat(0, p == 4, gen(0, p), p == 4);
    chk_state("clr_eol");
    chk("clr_eol_err", err, 4'b0100);
    for (int ln = 1; ln < SCRH; ln++) send_line(0, SCRW, ln, 1, 0);
    chk_state("early_sof_end");
    drain();
    send_line(1, SCRW, 0, 1, 0);
    send_line(0, SCRW, 1, 1, 0);
    send_line(0, 3, 2, 0, 0);
    @(negedge clk);
    s_if.tvalid = 0;
    rstn = 0;
    #1;
    chk_zero("mid_reset");
    m_in = 0;
    m_pix = 0;
    m_line = 0;
    m_cnt = 0;
    m_err = 0;
    m_sum = 0;
    m_fsum = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1;
    pat = 1;
    send_frame();
    chk_state("after_reset");
    chk("after_reset_cnt", frame_cnt, 1);
`ifdef FRAME_CHECKSUM_EN
    chk("after_reset_sum496", frame_sum, 496);
`endif
    drain();
    chk("final_done", done_seen, m_done);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
